// File: rtl/tdc_cal_pkg.sv
// Shared state type and width helpers for the TDC calibration sequencer.
// Optional min/max tracking is enabled by defining TDC_CAL_MINMAX_EN.
package tdc_cal_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TRIG     = 3'd1,
        WAIT_RES = 3'd2,
        GAP      = 3'd3,
        CALC     = 3'd4,
        ERROR    = 3'd5
    } tdc_cal_state_t;

    localparam int TDC_W_DEFAULT          = 16;
    localparam int N_SAMPLES_LOG2_DEFAULT = 4;

    function automatic int acc_width(input int tdc_w, input int n_log2);
        return tdc_w + n_log2;
    endfunction

    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/tdc_cal_accumulator.sv
// Sample accumulator and counter for one calibration run; exposes the truncated mean.
// Running min/max trackers exist only when TDC_CAL_MINMAX_EN is defined.
module tdc_cal_accumulator
    import tdc_cal_pkg::*;
#(
    parameter int TDC_W          = TDC_W_DEFAULT,
    parameter int N_SAMPLES_LOG2 = N_SAMPLES_LOG2_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             add,
    input  logic [TDC_W-1:0] sample,
    output logic             last_sample,
    output logic [TDC_W-1:0] mean
`ifdef TDC_CAL_MINMAX_EN
    ,
    output logic [TDC_W-1:0] run_min,
    output logic [TDC_W-1:0] run_max
`endif
);

    localparam int ACC_W = acc_width(TDC_W, N_SAMPLES_LOG2);
    localparam int CNT_W = N_SAMPLES_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << N_SAMPLES_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            acc_d = acc_q + ACC_W'(sample);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_sample = (cnt_q == LAST_IDX);
    assign mean        = acc_q[ACC_W-1:N_SAMPLES_LOG2];

`ifdef TDC_CAL_MINMAX_EN
    logic [TDC_W-1:0] min_q, min_d;
    logic [TDC_W-1:0] max_q, max_d;

    // The first sample of a run (counter still 0) seeds both trackers.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (add && !clear) begin
            if (cnt_q == '0 || sample < min_q) min_d = sample;
            if (cnt_q == '0 || sample > max_q) max_d = sample;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign run_min = min_q;
    assign run_max = max_q;
`endif

endmodule

// File: rtl/tdc_cal_sequencer.sv
// Calibration sequencer: triggers reference pulses, averages the TDC results, publishes the mean.
// Define TDC_CAL_MINMAX_EN to also publish the run's minimum and maximum samples.
module tdc_cal_sequencer
    import tdc_cal_pkg::*;
#(
    parameter int TDC_W          = 16,
    parameter int N_SAMPLES_LOG2 = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             trigger,
    input  logic             tdc_valid,
    input  logic [TDC_W-1:0] tdc_value,
    output logic             busy,
    output logic             done,
    output logic             cal_valid,
    output logic [TDC_W-1:0] cal_value,
    output logic             error,
    output logic [TDC_W-1:0] cal_min,
    output logic [TDC_W-1:0] cal_max
);

    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    tdc_cal_state_t   state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             trigger_q, trigger_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cal_valid_q, cal_valid_d;
    logic             error_q, error_d;
    logic [TDC_W-1:0] cal_value_q, cal_value_d;

    logic             acc_clear, acc_add, last_sample;
    logic [TDC_W-1:0] mean;

    assign acc_clear = ((state_q == IDLE) || (state_q == ERROR)) && start;
    assign acc_add   = (state_q == WAIT_RES) && tdc_valid;

`ifdef TDC_CAL_MINMAX_EN
    logic [TDC_W-1:0] run_min, run_max;
`endif

    tdc_cal_accumulator #(
        .TDC_W          (TDC_W),
        .N_SAMPLES_LOG2 (N_SAMPLES_LOG2)
    ) u_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (acc_clear),
        .add         (acc_add),
        .sample      (tdc_value),
        .last_sample (last_sample),
        .mean        (mean)
`ifdef TDC_CAL_MINMAX_EN
        ,
        .run_min     (run_min),
        .run_max     (run_max)
`endif
    );

    // Outputs are computed one state ahead so each is a plain flop.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        trigger_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cal_valid_d = cal_valid_q;
        cal_value_d = cal_value_q;
        error_d     = error_q;
        case (state_q)
            IDLE, ERROR: begin
                if (start) begin
                    state_d   = TRIG;
                    trigger_d = 1'b1;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                end
            end
            TRIG: begin
                state_d = WAIT_RES;
                tmo_d   = '0;
            end
            WAIT_RES: begin
                // A sample arriving on the final timeout cycle still counts.
                if (tdc_valid) begin
                    if (last_sample) begin
                        state_d = CALC;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = ERROR;
                    error_d     = 1'b1;
                    busy_d      = 1'b0;
                    cal_valid_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d   = TRIG;
                    trigger_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            CALC: begin
                cal_value_d = mean;
                cal_valid_d = 1'b1;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            gap_q       <= '0;
            trigger_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cal_valid_q <= 1'b0;
            cal_value_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            trigger_q   <= trigger_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cal_valid_q <= cal_valid_d;
            cal_value_q <= cal_value_d;
            error_q     <= error_d;
        end
    end

`ifdef TDC_CAL_MINMAX_EN
    logic [TDC_W-1:0] cal_min_q, cal_min_d;
    logic [TDC_W-1:0] cal_max_q, cal_max_d;

    always_comb begin
        cal_min_d = cal_min_q;
        cal_max_d = cal_max_q;
        if (state_q == CALC) begin
            cal_min_d = run_min;
            cal_max_d = run_max;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cal_min_q <= '0;
            cal_max_q <= '0;
        end else begin
            cal_min_q <= cal_min_d;
            cal_max_q <= cal_max_d;
        end
    end

    assign cal_min = cal_min_q;
    assign cal_max = cal_max_q;
`else
    assign cal_min = '0;
    assign cal_max = '0;
`endif

    assign trigger   = trigger_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cal_valid = cal_valid_q;
    assign cal_value = cal_value_q;
    assign error     = error_q;

endmodule

// File: tb/tb_tdc_cal_sequencer.sv
// Self-checking bench for tdc_cal_sequencer: directed scenarios plus randomized runs
// compared against a run-level model (sum, shift, min, max) kept in the bench.
module tb_tdc_cal_sequencer;

   localparam int TDC_W  = 16;
   localparam int NLOG2  = 2;
   localparam int NS     = 1 << NLOG2;
   localparam int GAP    = 6;
   localparam int TMO    = 10;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             tdcValid = 1'b0;
   logic [TDC_W-1:0] tdcValue = '0;
   logic             trigger, busy, done, calValid, error;
   logic [TDC_W-1:0] calValue, calMin, calMax;

   int checks = 0;
   int errors = 0;

   // Per-run stimulus: the sample value and the trigger-to-valid delay of each pulse.
   int sampleQ[NS];
   int delayQ[NS];

   // Value the sticky cal_valid flag should hold while a new run is in progress.
   logic calValidExp = 1'b0;

   tdc_cal_sequencer #(
      .TDC_W          (TDC_W),
      .N_SAMPLES_LOG2 (NLOG2),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .trigger   (trigger),
      .tdc_valid (tdcValid),
      .tdc_value (tdcValue),
      .busy      (busy),
      .done      (done),
      .cal_valid (calValid),
      .cal_value (calValue),
      .error     (error),
      .cal_min   (calMin),
      .cal_max   (calMax)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Safety net so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Waits for the next trigger and checks it appears exactly expOff negedges later;
   // optionally injects a stray start and tdc_valid early in the wait (inside GAP).
   task automatic waitTrigger(input int expOff, input bit stray, input string tag);
      int off;
      off = -1;
      for (int k = 1; k <= expOff + 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start    = 1'b0;
            tdcValid = 1'b0;
         end
         if (stray && k == 2) begin
            start    = 1'b1;
            tdcValid = 1'b1;
            tdcValue = 16'h5A5A;
         end
         if (stray && k == 3) begin
            start    = 1'b0;
            tdcValid = 1'b0;
         end
         if (trigger) begin
            off = k;
            break;
         end
      end
      start    = 1'b0;
      tdcValid = 1'b0;
      checkOutput(tag, off, expOff);
   endtask

   // Counts trigger pulses over a window in which none are allowed.
   task automatic checkNoTrigger(input int cycles, input string tag);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (trigger) seen++;
      end
      checkOutput(tag, seen, 0);
   endtask

   // Runs one calibration: timeoutIdx drops the response to that pulse, resetIdx
   // asserts reset while waiting for that pulse, stray injects ignored inputs in GAP.
   task automatic applyStimulus(input int timeoutIdx, input int resetIdx, input bit stray);
      int sum, mn, mx;
      sum = 0;
      mn  = 0;
      mx  = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < NS; i++) begin
         if (i == 0) waitTrigger(1, 1'b0, "firstTrigger");
         else        waitTrigger(GAP + 1, stray && (i == 1), "gapTrigger");
         checkOutput("busyInRun", busy, 1'b1);
         if (i == 0) begin
            checkOutput("calValidHeld", calValid, calValidExp);
            checkOutput("errorCleared", error, 1'b0);
         end
         if (i == resetIdx) begin
            repeat (2) @(negedge clk);
            reset_n = 1'b0;
            #1;
            checkOutput("resetFlags", {trigger, busy, done, calValid, error}, 5'b0);
            checkOutput("resetCalValue", calValue, 0);
            checkOutput("resetMinMax", {calMin, calMax}, 0);
            checkNoTrigger(TMO + GAP + 3, "resetNoTrigger");
            reset_n = 1'b1;
            calValidExp = 1'b0;
            return;
         end
         if (i == timeoutIdx) begin
            repeat (TMO) @(negedge clk);
            checkOutput("preTimeoutError", error, 1'b0);
            @(negedge clk);
            checkOutput("timeoutError", error, 1'b1);
            checkOutput("timeoutBusy", busy, 1'b0);
            checkOutput("timeoutCalValid", calValid, 1'b0);
            checkNoTrigger(GAP + 3, "timeoutNoTrigger");
            calValidExp = 1'b0;
            return;
         end
         repeat (delayQ[i]) @(negedge clk);
         tdcValid = 1'b1;
         tdcValue = TDC_W'(sampleQ[i]);
         if (i == 0 || sampleQ[i] < mn) mn = sampleQ[i];
         if (i == 0 || sampleQ[i] > mx) mx = sampleQ[i];
         sum += sampleQ[i];
      end
      @(negedge clk);
      tdcValid = 1'b0;
      checkOutput("doneEarly", done, 1'b0);
      @(negedge clk);
      checkOutput("done", done, 1'b1);
      checkOutput("calValue", calValue, sum >> NLOG2);
      checkOutput("calValid", calValid, 1'b1);
      checkOutput("busyAfter", busy, 1'b0);
      checkOutput("errorAfter", error, 1'b0);
`ifdef TDC_CAL_MINMAX_EN
      checkOutput("calMin", calMin, mn);
      checkOutput("calMax", calMax, mx);
`else
      checkOutput("calMinTied", calMin, 0);
      checkOutput("calMaxTied", calMax, 0);
`endif
      @(negedge clk);
      checkOutput("doneOneCycle", done, 1'b0);
      checkNoTrigger(GAP + 3, "idleNoTrigger");
      calValidExp = 1'b1;
   endtask

   // Directed scenarios first, then randomized runs with occasional timeouts.
   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetFlagsInit", {trigger, busy, done, calValid, error}, 5'b0);
      checkOutput("resetValueInit", calValue, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idleFlags", {trigger, busy, done, calValid, error}, 5'b0);

      sampleQ = '{100, 102, 98, 101};
      delayQ  = '{5, 5, 5, 5};
      applyStimulus(-1, -1, 1'b0);

      applyStimulus(2, -1, 1'b0);
      applyStimulus(-1, -1, 1'b0);

      applyStimulus(-1, -1, 1'b1);

      applyStimulus(-1, 1, 1'b0);
      applyStimulus(-1, -1, 1'b0);

      sampleQ = '{32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF};
      delayQ  = '{TMO, 1, TMO, TMO};
      applyStimulus(-1, -1, 1'b0);

      sampleQ = '{7, 3, 9, 5};
      delayQ  = '{2, 3, 4, 5};
      applyStimulus(-1, -1, 1'b0);

      for (int r = 0; r < 24; r++) begin
         for (int j = 0; j < NS; j++) begin
            sampleQ[j] = int'($urandom_range(0, 16'hFFFF));
            delayQ[j]  = int'($urandom_range(1, TMO));
         end
         if ($urandom_range(0, 4) == 0) applyStimulus(int'($urandom_range(0, NS - 1)), -1, 1'b0);
         else                            applyStimulus(-1, -1, r[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
